// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line levels and the
// clocks-per-bit helper. The transmitter and its baud counter use the same items.
// Latency: n/a (package). Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Rounded number of system clocks per serial bit.
    function automatic int clks_per_bit(input real clock, input real baud);
        return int'(clock / baud);
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit timer: down-counter that ticks once per bit period, loadable to half or full period.
// Latency: tick_o is high in the cycle the counter reads 0; it auto-reloads to a full period.
// Backpressure: none; free-running while en_i is high, parked at 0 otherwise.
//
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   en_i           count enable (receiver not idle)
//   load_half_i    load CLKS_PER_BIT/2-1: next tick lands on the start-bit midpoint
//   load_full_i    load CLKS_PER_BIT-1: next tick one full bit later
//   tick_o         sample strobe
module uart_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 5,
    parameter int CW           = $clog2(CLKS_PER_BIT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic load_half_i,
    input  logic load_full_i,
    output logic tick_o
);

    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_half_i) begin
            cnt_d = HALF_M1;
        end else if (load_full_i) begin
            cnt_d = FULL_M1;
        end else if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = FULL_M1;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start/DATA_BITS (LSB first)/[even parity]/stop, mid-bit sampling, valid/ready output.
// Latency: rx_valid_o rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 clocks after the rx_i fall.
// Backpressure: one-byte holding register; a good frame arriving while it is unaccepted is dropped with overrun_o.
//
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   rx_i                serial line (idle high, asynchronous)
//   rx_data_o/_valid_o  received byte, held until rx_ready_i
//   rx_ready_i          consumer accept
//   frame_err_o         1-cycle pulse: stop bit sampled low
//   overrun_o           1-cycle pulse: good frame lost to an unaccepted byte
//   busy_o              receiver not idle
//   parity_err_o        (only with UART_RX_PARITY_EN) 1-cycle pulse: even-parity mismatch
module uart_receiver
    import uart_pkg::*;
#(
    parameter real CLOCK        = 100e6,
    parameter real BAUD_RATE    = 20e6,
    parameter int  DATA_BITS    = 8,
    parameter int  CLKS_PER_BIT = clks_per_bit(CLOCK, BAUD_RATE),
    parameter int  CW           = $clog2(CLKS_PER_BIT + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err_o,
`endif
    output logic                 busy_o
);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 rxs;
    rx_state_t            state_q;
    logic [3:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 busy_q;
    logic                 tick;
    logic                 load_half;
    logic                 load_full;
    logic                 par_bad;

    // Two-flop synchronizer, reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    assign rxs = sync2_q;

    // Half-period load on the start edge puts every later tick at a bit midpoint.
    assign load_half = (state_q == RX_IDLE) && (rxs == START_LEVEL);
    assign load_full = (state_q == RX_START) && tick && (rxs == START_LEVEL);

    uart_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CW           (CW)
    ) u_bit_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (state_q != RX_IDLE),
        .load_half_i  (load_half),
        .load_full_i  (load_full),
        .tick_o       (tick)
    );

`ifdef UART_RX_PARITY_EN
    logic par_q;
    logic parity_err_q;
    assign par_bad      = ^{shift_q, par_q};
    assign parity_err_o = parity_err_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RX_IDLE;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // Acceptance clears valid; a frame completing this cycle may re-set it below.
            if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                RX_IDLE: begin
                    if (rxs == START_LEVEL) begin
                        state_q <= RX_START;
                        busy_q  <= 1'b1;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rxs == START_LEVEL) begin
                            state_q <= RX_DATA;
                            bit_q   <= '0;
                        end else begin
                            // Line went back high before mid-start: glitch, ignore.
                            state_q <= RX_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + 4'd1;
                        if (bit_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= RX_PARITY;
`else
                            state_q <= RX_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (tick) begin
                        par_q   <= rxs;
                        state_q <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (tick) begin
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_bad;
`endif
                        if (rxs == IDLE_LEVEL) begin
                            // Back to idle at the stop midpoint so a following start edge is caught.
                            state_q <= RX_IDLE;
                            busy_q  <= 1'b0;
                            if (!par_bad) begin
                                if (!rx_valid_q || rx_ready_i) begin
                                    rx_data_q  <= shift_q;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    // Hold off through a break until the line returns to idle.
                    if (rxs == IDLE_LEVEL) begin
                        state_q <= RX_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 10 clocks per bit (100 MHz / 10 Mbit/s).
module tb_uart_receiver;

    localparam int CPB = 10;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_o;
`endif

    uart_receiver #(
        .CLOCK      (100e6),
        .BAUD_RATE  (10e6),
        .DATA_BITS  (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
`ifdef UART_RX_PARITY_EN
        .parity_err_o (parity_err_o),
`endif
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    int         n_acc = 0;
    int         n_vld_cyc = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         rise_cyc = 0;
    logic       vld_prev = 1'b0;
    logic [7:0] acc_log [0:63];

    always @(negedge clk_i) begin
        if (rx_valid_o) begin
            n_vld_cyc = n_vld_cyc + 1;
            if (!vld_prev) rise_cyc = cyc;
        end
        vld_prev = rx_valid_o;
        if (rx_valid_o && rx_ready_i) begin
            acc_log[n_acc % 64] = rx_data_o;
            n_acc = n_acc + 1;
        end
        if (frame_err_o) n_ferr = n_ferr + 1;
        if (overrun_o) n_ovr = n_ovr + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Drive one line level for n clocks; starts and ends just after a rising edge.
    task automatic drive_bit(input logic v, input int n);
        rx_i = v;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v, output int t0);
        t0 = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        drive_bit(stop_v, CPB);
    endtask

    task automatic pulse_ready();
        rx_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rx_ready_i = 1'b0;
    endtask

    int t0;
    int a0, v0, f0, o0;

    task automatic snap();
        a0 = n_acc;
        v0 = n_vld_cyc;
        f0 = n_ferr;
        o0 = n_ovr;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i      = 1'b1;
        rx_i       = 1'b1;
        rx_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_data",  32'(rx_data_o),   32'h0);
        check("rst_valid", 32'(rx_valid_o),  32'h0);
        check("rst_ferr",  32'(frame_err_o), 32'h0);
        check("rst_ovr",   32'(overrun_o),   32'h0);
        check("rst_busy",  32'(busy_o),      32'h0);
        rst_i = 1'b0;
        drive_bit(1'b1, 5);

        // 1: clean 0xA5 with consumer ready
        rx_ready_i = 1'b1;
        snap();
        send_byte(8'hA5, 1'b1, t0);
        drive_bit(1'b1, 5);
        check("a5_latency", 32'(rise_cyc - t0), 32'd98);
        check("a5_count",   32'(n_acc - a0), 32'd1);
        check("a5_data",    32'(acc_log[(n_acc - 1) % 64]), 32'hA5);
        check("a5_vld_cyc", 32'(n_vld_cyc - v0), 32'd1);
        check("a5_ferr",    32'(n_ferr - f0), 32'd0);
        check("a5_ovr",     32'(n_ovr - o0), 32'd0);

        // 2: 3-cycle glitch
        snap();
        drive_bit(1'b0, 3);
        check("glitch_busy_hi", 32'(busy_o), 32'h1);
        drive_bit(1'b1, 9);
        check("glitch_busy_lo", 32'(busy_o), 32'h0);
        drive_bit(1'b1, 10);
        check("glitch_vld", 32'(n_vld_cyc - v0), 32'd0);

        // 3: 0x3C with low stop bit, then line held low
        snap();
        send_byte(8'h3C, 1'b0, t0);
        drive_bit(1'b0, 30);
        check("ferr_count", 32'(n_ferr - f0), 32'd1);
        check("ferr_busy",  32'(busy_o), 32'h1);
        check("ferr_vld",   32'(n_vld_cyc - v0), 32'd0);
        drive_bit(1'b1, 6);
        check("ferr_release", 32'(busy_o), 32'h0);
        drive_bit(1'b1, 20);
        check("ferr_no_more", 32'(n_ferr - f0), 32'd1);

        // 4: back-to-back 0x11, 0x22 with consumer stalled
        rx_ready_i = 1'b0;
        snap();
        send_byte(8'h11, 1'b1, t0);
        send_byte(8'h22, 1'b1, t0);
        drive_bit(1'b1, 3);
        check("ovr_count", 32'(n_ovr - o0), 32'd1);
        check("ovr_valid", 32'(rx_valid_o), 32'h1);
        check("ovr_data",  32'(rx_data_o), 32'h11);
        pulse_ready();
        drive_bit(1'b1, 2);
        check("ovr_drain_vld", 32'(rx_valid_o), 32'h0);
        check("ovr_acc_cnt",   32'(n_acc - a0), 32'd1);
        check("ovr_acc_data",  32'(acc_log[(n_acc - 1) % 64]), 32'h11);

        // 5: 0x55 pending, 0x66 completes in the accept cycle
        snap();
        send_byte(8'h55, 1'b1, t0);
        drive_bit(1'b1, 3);
        check("p55_valid", 32'(rx_valid_o), 32'h1);
        check("p55_data",  32'(rx_data_o), 32'h55);
        fork
            send_byte(8'h66, 1'b1, t0);
            begin
                repeat (97) @(posedge clk_i);
                #1;
                rx_ready_i = 1'b1;
                @(posedge clk_i);
                #1;
                rx_ready_i = 1'b0;
            end
        join
        drive_bit(1'b1, 2);
        check("p66_valid",   32'(rx_valid_o), 32'h1);
        check("p66_data",    32'(rx_data_o), 32'h66);
        check("p66_ovr",     32'(n_ovr - o0), 32'd0);
        check("p66_acc_cnt", 32'(n_acc - a0), 32'd1);
        check("p66_acc_55",  32'(acc_log[(n_acc - 1) % 64]), 32'h55);
        pulse_ready();
        drive_bit(1'b1, 2);
        check("p66_acc_66", 32'(acc_log[(n_acc - 1) % 64]), 32'h66);
        check("p66_drain",  32'(rx_valid_o), 32'h0);

        // 6: reset in the middle of data bit 4, with a byte pending
        send_byte(8'h81, 1'b1, t0);
        drive_bit(1'b1, 3);
        drive_bit(1'b0, CPB);          // start
        drive_bit(1'b0, 4 * CPB);      // data bits 0..3
        drive_bit(1'b0, CPB / 2);      // into bit 4
        check("mid_busy",  32'(busy_o), 32'h1);
        check("mid_valid", 32'(rx_valid_o), 32'h1);
        rst_i = 1'b1;
        #1;
        check("arst_data",  32'(rx_data_o),   32'h0);
        check("arst_valid", 32'(rx_valid_o),  32'h0);
        check("arst_busy",  32'(busy_o),      32'h0);
        check("arst_ferr",  32'(frame_err_o), 32'h0);
        check("arst_ovr",   32'(overrun_o),   32'h0);
        rx_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drive_bit(1'b1, 20);
        rx_ready_i = 1'b1;
        snap();
        send_byte(8'h0F, 1'b1, t0);
        drive_bit(1'b1, 5);
        check("post_rst_cnt",  32'(n_acc - a0), 32'd1);
        check("post_rst_data", 32'(acc_log[(n_acc - 1) % 64]), 32'h0F);
        check("post_rst_lat",  32'(rise_cyc - t0), 32'd98);
        check("post_rst_ferr", 32'(n_ferr - f0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
